// File: rtl/utm_pkg.sv
// Shared types and constants for the universal Turing machine datapath.
// Imported by the tape register file and the tape controller.
package utm_pkg;

    localparam int SYM_W   = 3;
    localparam int STATE_W = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [STATE_W-1:0] HALT_STATE_DEF = 3'd7;
    localparam logic [STATE_W-1:0] STATE_A        = 3'd0;

    typedef enum logic [2:0] {
        FSM_IDLE   = 3'd0,
        FSM_READ   = 3'd1,
        FSM_EXEC   = 3'd2,
        FSM_HALTED = 3'd3,
        FSM_FAULT  = 3'd4
    } fsm_e;

    typedef struct packed {
        logic [STATE_W-1:0] next_state;
        logic [SYM_W-1:0]   new_sym;
        logic               dir;
    } tt_resp_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/utm_tape.sv
// Tape register file: synchronous clear, one synchronous write port,
// two asynchronous read ports (head and debug readback).
module utm_tape
    import utm_pkg::*;
#(
    parameter int TAPE_LEN = 16,
    parameter int ADDR_W   = $clog2(TAPE_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SYM_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [SYM_W-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [SYM_W-1:0]  rdata_b
);

    logic [SYM_W-1:0] cells [TAPE_LEN];

    // Clear every cell on reset, otherwise commit the single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                cells[i] <= '0;
            end
        end else if (we) begin
            cells[waddr] <= wdata;
        end
    end

    assign rdata_a = cells[raddr_a];
    assign rdata_b = cells[raddr_b];

endmodule

// File: rtl/utm_tape_controller.sv
// Sequencer for the UTM: owns tape, head and machine state, and applies
// one transition-table response every READ/EXEC pair of cycles.
module utm_tape_controller
    import utm_pkg::*;
#(
    parameter int                 TAPE_LEN   = 16,
    parameter int                 START_POS  = 8,
    parameter logic [STATE_W-1:0] HALT_STATE = HALT_STATE_DEF,
    parameter int                 HEAD_W     = $clog2(TAPE_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_en,
    input  logic [HEAD_W-1:0]  load_addr,
    input  logic [SYM_W-1:0]   load_sym,
    input  logic [HEAD_W-1:0]  rd_addr,
    output logic [SYM_W-1:0]   rd_sym,
    output logic [STATE_W-1:0] tt_state,
    output logic [SYM_W-1:0]   tt_sym,
    input  logic [STATE_W-1:0] tt_next_state,
    input  logic [SYM_W-1:0]   tt_new_sym,
    input  logic               tt_dir,
    output logic [HEAD_W-1:0]  head_pos,
    output logic               running,
    output logic               halted,
    output logic               fault,
    output logic [15:0]        step_count
);

    localparam logic [HEAD_W-1:0] HEAD_START = HEAD_W'(START_POS);
    localparam logic [HEAD_W-1:0] HEAD_LAST  = HEAD_W'(TAPE_LEN - 1);

    fsm_e               fsm_q;
    logic [STATE_W-1:0] state_q;
    logic [SYM_W-1:0]   sym_q;
    logic [HEAD_W-1:0]  head_q;
    logic [15:0]        steps_q;
    logic               halted_q;
    logic               fault_q;

    tt_resp_t           resp;
    logic [SYM_W-1:0]   head_sym;
    logic               in_exec;
    logic               idle_like;
    logic               load_ok;
    logic               tape_we;
    logic [HEAD_W-1:0]  tape_waddr;
    logic [SYM_W-1:0]   tape_wdata;
    logic               is_halt;
    logic               off_tape;

    assign resp = '{next_state: tt_next_state,
                    new_sym:    tt_new_sym,
                    dir:        tt_dir};

    assign in_exec   = (fsm_q == FSM_EXEC);
    assign idle_like = (fsm_q == FSM_IDLE)
                    || (fsm_q == FSM_HALTED)
                    || (fsm_q == FSM_FAULT);
    assign load_ok   = load_en && idle_like;

    // Host loads and EXEC write-back are mutually exclusive by FSM state.
    always_comb begin
        tape_we    = 1'b0;
        tape_waddr = load_addr;
        tape_wdata = load_sym;
        if (in_exec) begin
            tape_we    = 1'b1;
            tape_waddr = head_q;
            tape_wdata = resp.new_sym;
        end else if (load_ok) begin
            tape_we    = 1'b1;
        end
    end

    // Decide where the current EXEC response would take the head.
    always_comb begin
        is_halt  = (resp.next_state == HALT_STATE);
        off_tape = (resp.dir == DIR_RIGHT)
                 ? (head_q == HEAD_LAST)
                 : (head_q == '0);
    end

    utm_tape #(
        .TAPE_LEN (TAPE_LEN),
        .ADDR_W   (HEAD_W)
    ) u_tape (
        .clk     (clk),
        .reset   (reset),
        .we      (tape_we),
        .waddr   (tape_waddr),
        .wdata   (tape_wdata),
        .raddr_a (head_q),
        .rdata_a (head_sym),
        .raddr_b (rd_addr),
        .rdata_b (rd_sym)
    );

    // Run sequencer: start, fetch symbol, apply transition, end run.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= FSM_IDLE;
            state_q  <= STATE_A;
            sym_q    <= '0;
            head_q   <= HEAD_START;
            steps_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            unique case (fsm_q)
                FSM_IDLE, FSM_HALTED, FSM_FAULT: begin
                    if (start) begin
                        fsm_q    <= FSM_READ;
                        state_q  <= STATE_A;
                        head_q   <= HEAD_START;
                        steps_q  <= '0;
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                    end
                end
                FSM_READ: begin
                    sym_q <= head_sym;
                    fsm_q <= FSM_EXEC;
                end
                FSM_EXEC: begin
                    state_q <= resp.next_state;
                    steps_q <= sat_inc16(steps_q);
                    if (is_halt) begin
                        fsm_q    <= FSM_HALTED;
                        halted_q <= 1'b1;
                    end else if (off_tape) begin
                        fsm_q   <= FSM_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        fsm_q  <= FSM_READ;
                        head_q <= (resp.dir == DIR_RIGHT)
                                ? head_q + 1'b1
                                : head_q - 1'b1;
                    end
                end
                default: begin
                    fsm_q <= FSM_IDLE;
                end
            endcase
        end
    end

    assign tt_state   = state_q;
    assign tt_sym     = sym_q;
    assign head_pos   = head_q;
    assign running    = (fsm_q == FSM_READ) || (fsm_q == FSM_EXEC);
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign step_count = steps_q;

endmodule

// File: tb/tb_utm_tape_controller.sv
// Directed bench for the UTM tape controller with a step-level model
// checked every cycle, plus hand-computed literal expectations.
module tb_utm_tape_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [2:0]  load_sym;
    logic [3:0]  rd_addr;
    logic [2:0]  rd_sym;
    logic [2:0]  tt_state;
    logic [2:0]  tt_sym;
    logic [2:0]  tt_next_state;
    logic [2:0]  tt_new_sym;
    logic        tt_dir;
    logic [3:0]  head_pos;
    logic        running;
    logic        halted;
    logic        fault;
    logic [15:0] step_count;

    logic        start2;
    logic [3:0]  rd_addr2;
    logic [2:0]  rd_sym2;
    logic [2:0]  tt_state2;
    logic [2:0]  tt_sym2;
    logic [2:0]  tt_next_state2;
    logic [2:0]  tt_new_sym2;
    logic        tt_dir2;
    logic [3:0]  head_pos2;
    logic        running2;
    logic        halted2;
    logic        fault2;
    logic [15:0] step_count2;

    int nvec = 0;
    int nerr = 0;
    int tbl_mode = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Bench-side transition tables, returned as {next_state, new_sym, dir}.
    function automatic logic [6:0] tt_lookup(input int mode,
                                             input logic [2:0] st,
                                             input logic [2:0] sy);
        case (mode)
            0: begin
                if (st == 3'd0 && sy == 3'd0) return {3'd1, 3'd1, 1'b1};
                if (st == 3'd1 && sy == 3'd0) return {3'd7, 3'd2, 1'b0};
                return {3'd7, sy, 1'b1};
            end
            1: begin
                if (sy == 3'd0) return {3'd7, sy, 1'b1};
                return {3'd0, sy, 1'b1};
            end
            2: return {3'd0, 3'd1, 1'b0};
            default: return {3'd0, sy, 1'b1};
        endcase
    endfunction

    assign {tt_next_state, tt_new_sym, tt_dir} =
        tt_lookup(tbl_mode, tt_state, tt_sym);
    assign {tt_next_state2, tt_new_sym2, tt_dir2} =
        tt_lookup(2, tt_state2, tt_sym2);

    utm_tape_controller #(.TAPE_LEN(16), .START_POS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_sym      (load_sym),
        .rd_addr       (rd_addr),
        .rd_sym        (rd_sym),
        .tt_state      (tt_state),
        .tt_sym        (tt_sym),
        .tt_next_state (tt_next_state),
        .tt_new_sym    (tt_new_sym),
        .tt_dir        (tt_dir),
        .head_pos      (head_pos),
        .running       (running),
        .halted        (halted),
        .fault         (fault),
        .step_count    (step_count)
    );

    utm_tape_controller #(.TAPE_LEN(16), .START_POS(0)) dut0 (
        .clk           (clk),
        .reset         (reset),
        .start         (start2),
        .load_en       (1'b0),
        .load_addr     (4'd0),
        .load_sym      (3'd0),
        .rd_addr       (rd_addr2),
        .rd_sym        (rd_sym2),
        .tt_state      (tt_state2),
        .tt_sym        (tt_sym2),
        .tt_next_state (tt_next_state2),
        .tt_new_sym    (tt_new_sym2),
        .tt_dir        (tt_dir2),
        .head_pos      (head_pos2),
        .running       (running2),
        .halted        (halted2),
        .fault         (fault2),
        .step_count    (step_count2)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Step-level model: phase 0 = not running, 1 = fetch, 2 = apply.
    int         m_phase;
    logic [2:0] m_tape [16];
    int         m_head;
    logic [2:0] m_state;
    logic [2:0] m_sym;
    int         m_steps;
    bit         m_halted;
    bit         m_fault;

    always @(posedge clk) begin : model
        logic [6:0] r;
        int         nh;
        if (reset) begin
            m_phase  = 0;
            foreach (m_tape[i]) m_tape[i] = 3'd0;
            m_head   = 8;
            m_state  = 3'd0;
            m_sym    = 3'd0;
            m_steps  = 0;
            m_halted = 0;
            m_fault  = 0;
        end else if (m_phase == 0) begin
            if (load_en) m_tape[load_addr] = load_sym;
            if (start) begin
                m_state  = 3'd0;
                m_head   = 8;
                m_steps  = 0;
                m_halted = 0;
                m_fault  = 0;
                m_phase  = 1;
            end
        end else if (m_phase == 1) begin
            m_sym   = m_tape[m_head];
            m_phase = 2;
        end else begin
            r = tt_lookup(tbl_mode, m_state, m_sym);
            m_tape[m_head] = r[3:1];
            m_state = r[6:4];
            if (m_steps < 65535) m_steps = m_steps + 1;
            nh = r[0] ? m_head + 1 : m_head - 1;
            if (r[6:4] == 3'd7) begin
                m_halted = 1;
                m_phase  = 0;
            end else if (nh < 0 || nh > 15) begin
                m_fault = 1;
                m_phase = 0;
            end else begin
                m_head  = nh;
                m_phase = 1;
            end
        end
    end

    // Compare the main DUT against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("head_pos", 32'(head_pos), 32'(m_head));
            chk("running", 32'(running), 32'(m_phase != 0));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("step_count", 32'(step_count), 32'(m_steps));
            chk("tt_state", 32'(tt_state), 32'(m_state));
            chk("tt_sym", 32'(tt_sym), 32'(m_sym));
            chk("rd_sym", 32'(rd_sym), 32'(m_tape[rd_addr]));
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!(halted || fault) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("run_done", 32'(halted | fault), 32'd1);
        #1;
    endtask

    task automatic read_cell(input logic [3:0] a,
                             input logic [2:0] exp,
                             input string nm);
        rd_addr = a;
        @(negedge clk);
        chk(nm, 32'(rd_sym), 32'(exp));
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = 4'd0;
        load_sym  = 3'd0;
        rd_addr   = 4'd0;
        start2    = 1'b0;
        rd_addr2  = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        #1 reset = 1'b0;

        for (int i = 0; i < 16; i++) read_cell(4'(i), 3'd0, "reset_cell");
        @(negedge clk);
        chk("reset_head", 32'(head_pos), 32'd8);
        chk("reset_steps", 32'(step_count), 32'd0);
        chk("reset_flags", 32'({running, halted, fault}), 32'd0);
        #1;

        tbl_mode = 0;
        start = 1'b1;
        @(negedge clk);
        chk("t2_running", 32'(running), 32'd1);
        #1 start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t2_not_yet", 32'(halted), 32'd0);
        end
        @(negedge clk);
        chk("t2_halted", 32'(halted), 32'd1);
        chk("t2_steps", 32'(step_count), 32'd2);
        chk("t2_head", 32'(head_pos), 32'd9);
        #1;
        read_cell(4'd8, 3'd1, "t2_tape8");
        read_cell(4'd9, 3'd2, "t2_tape9");

        load_en = 1'b1;
        load_addr = 4'd8;
        load_sym = 3'b101;
        @(negedge clk);
        #1 load_en = 1'b0;
        tbl_mode = 1;
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("t3_exec_sym", 32'(tt_sym), 32'b101);
        chk("t3_exec_state", 32'(tt_state), 32'd0);
        #1;
        wait_done();
        chk("t3_halted", 32'(halted), 32'd1);
        read_cell(4'd8, 3'b101, "t3_tape8");

        start2 = 1'b1;
        @(negedge clk);
        #1 start2 = 1'b0;
        @(negedge clk);
        chk("t4_no_fault_yet", 32'(fault2), 32'd0);
        @(negedge clk);
        chk("t4_fault", 32'(fault2), 32'd1);
        chk("t4_halted", 32'(halted2), 32'd0);
        chk("t4_head", 32'(head_pos2), 32'd0);
        chk("t4_steps", 32'(step_count2), 32'd1);
        chk("t4_tape0", 32'(rd_sym2), 32'd1);
        #1;

        tbl_mode = 0;
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        load_en = 1'b1;
        load_addr = 4'd3;
        load_sym = 3'd6;
        repeat (2) @(negedge clk);
        #1 load_en = 1'b0;
        wait_done();
        read_cell(4'd3, 3'd0, "t5_ignored");
        load_en = 1'b1;
        @(negedge clk);
        chk("t5_loaded", 32'(rd_sym), 32'd6);
        #1 load_en = 1'b0;

        tbl_mode = 3;
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("t6_in_exec", 32'(running), 32'd1);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_running", 32'(running), 32'd0);
        chk("t6_head", 32'(head_pos), 32'd8);
        chk("t6_steps", 32'(step_count), 32'd0);
        chk("t6_flags", 32'({halted, fault}), 32'd0);
        chk("t6_state", 32'({tt_state, tt_sym}), 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) read_cell(4'(i), 3'd0, "t6_cleared");
        tbl_mode = 0;
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        wait_done();
        chk("t6_rerun_halted", 32'(halted), 32'd1);
        chk("t6_rerun_steps", 32'(step_count), 32'd2);
        read_cell(4'd8, 3'd1, "t6_tape8");
        read_cell(4'd9, 3'd2, "t6_tape9");
        read_cell(4'd3, 3'd0, "t6_tape3");

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/utm_tape_controller.md
# utm_tape_controller

Sequencer side of the universal Turing machine datapath. It owns the tape, head pointer and current machine state. Each step it presents `{state, symbol}` to the combinational transition table, then applies the returned `{next_state, new_sym, direction}` by writing the tape, moving the head and updating the state. It sits between the host load/readback interface and the transition-table user module, and drives that module's inputs.

## Interface
- `TAPE_LEN`, 16: tape cells; head width is `$clog2(TAPE_LEN)`.
- `START_POS`, 8: head position on reset and on every `start`.
- `HALT_STATE`, 3'd7: state code that ends a run (state 'H').
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a run; one-cycle pulse.
- `load_en`  in  1: write `load_sym` to `load_addr`.
- `load_addr`  in  4: tape preload address.
- `load_sym`  in  3: tape preload symbol.
- `rd_addr`  in  4: debug readback address.
- `rd_sym`  out  3: `tape[rd_addr]`, combinational.
- `tt_state`  out  3: current state to the transition table.
- `tt_sym`  out  3: current symbol to the transition table.
- `tt_next_state`  in  3: next state from the table.
- `tt_new_sym`  in  3: symbol to write, from the table.
- `tt_dir`  in  1: 1 = move right, 0 = move left.
- `head_pos`  out  4: current head index.
- `running`  out  1: FSM is in READ or EXEC.
- `halted`  out  1: last run reached `HALT_STATE`.
- `fault`  out  1: last run tried to move the head off the tape.
- `step_count`  out  16: completed steps, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, READ, EXEC, HALTED, FAULT.
- IDLE, HALTED, FAULT: `start` sets `state_q` to 0 (state 'A'), `head` to `START_POS` and `step_count` to 0, clears `halted` and `fault`, and moves to READ. Tape contents are kept.
- READ: `sym_q <= tape[head]`, then go to EXEC.
- EXEC: `tt_state = state_q` and `tt_sym = sym_q`; both come from registers and are stable for the whole cycle. At the clock edge:
  - `tape[head] <= tt_new_sym`
  - `state_q <= tt_next_state`
  - `step_count` increments, saturating.
  - If `tt_next_state == HALT_STATE`: go to HALTED and set `halted`. The head does not move.
  - Else if the move leaves the tape (`head == 0` with `tt_dir = 0`, or `head == TAPE_LEN-1` with `tt_dir = 1`): go to FAULT, set `fault`, leave the head where it is. The symbol write still commits.
  - Otherwise move the head by ±1 and go to READ.
- The halt check takes priority over the off-tape check when both apply.
- `load_en` is honoured only in IDLE, HALTED and FAULT; it is ignored while `running`.
- `load_en` and `start` in the same cycle: the load commits on that edge, and READ on the next cycle sees the loaded value.
- `start` while `running` is ignored.
- Outside EXEC, `tt_state` and `tt_sym` still show `state_q` and `sym_q`.

## Timing
- On reset: FSM = IDLE, `state_q` = 0, `sym_q` = 0, `head` = `START_POS`, every tape cell = 0, `step_count` = 0, `running` = `halted` = `fault` = 0.
- `reset` overrides everything, including mid-run and a simultaneous `start` or `load_en`.
- One machine step takes 2 cycles (READ, then EXEC).
- `start` at edge N puts READ in cycle N+1 and EXEC in N+2. The first step's results are visible after edge N+2.
- `halted` and `fault` rise on the same edge that commits the final write.
- `rd_sym` is asynchronous. It shows the new value the cycle after a write edge.

## Structure
- `utm_pkg` holds:
  - `SYM_W` = 3 and `STATE_W` = 3
  - `DIR_LEFT` = 0 and `DIR_RIGHT` = 1
  - the `HALT_STATE` default and the `STATE_A` code
  - the FSM state enum
- Sub-module `utm_tape`: `TAPE_LEN` × 3-bit register file with synchronous clear, one synchronous write port (the controller muxes between load and EXEC, which never conflict), and two asynchronous read ports (head, debug).

## Test plan
1. Reset, then read all 16 cells via `rd_addr` -> all 0. `head_pos` = 8, `running` = `halted` = `fault` = 0, `step_count` = 0.
2. Bench table: A/0 -> {B, 1, R}, B/0 -> {H, 2, L}. Pulse `start` -> `tape[8]` = 1, `tape[9]` = 2, `head_pos` = 9, `halted` = 1, `step_count` = 2, exactly 4 cycles after `start`.
3. Load `tape[8]` = 3'b101 with a table that echoes the symbol and moves right until state H -> the first EXEC shows `tt_sym` = 101, and the write-back preserves it.
4. `START_POS` = 0 with A/0 -> {A, 1, L} -> `fault` = 1 after one step, `tape[0]` = 1, `head_pos` = 0, `halted` = 0.
5. `load_en` to address 3 during a run -> `tape[3]` unchanged. The same load after `halted` -> `tape[3]` updated.
6. Assert `reset` during EXEC of an endless right-moving loop -> the next cycle shows every reset value, and `start` afterwards runs from a cleared tape.
